// File: rtl/dcache_store_queue.sv
// In-order store queue feeding the HPDcache request port: it classifies each store
// as cacheable or uncacheable, tags issued requests with a TID and throttles outstanding stores.
module dcache_store_queue #(
  parameter int unsigned DEPTH           = 8,
  parameter int unsigned ADDR_W          = 64,
  parameter int unsigned DATA_W          = 64,
  parameter int unsigned TID_W           = 3,
  parameter int unsigned MAX_OUTSTANDING = 7,
  parameter logic [63:0] CACHED_BASE     = 64'h8000_0000,
  parameter logic [63:0] CACHED_LEN      = 64'h4000_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  st_valid_i,
  output logic                  st_ready_o,
  input  logic [ADDR_W-1:0]     st_addr_i,
  input  logic [DATA_W-1:0]     st_data_i,
  input  logic [DATA_W/8-1:0]   st_be_i,
  output logic                  req_valid_o,
  input  logic                  req_ready_i,
  output logic [ADDR_W-1:0]     req_addr_o,
  output logic [DATA_W-1:0]     req_data_o,
  output logic [DATA_W/8-1:0]   req_be_o,
  output logic                  req_uc_o,
  output logic [TID_W-1:0]      req_tid_o,
  input  logic                  rsp_valid_i,
  input  logic [TID_W-1:0]      rsp_tid_i,
  output logic                  empty_o,
  output logic [TID_W:0]        outstanding_o,
  output logic                  rsp_err_o
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OUT_W = TID_W + 1;
  localparam int unsigned CMP_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    UC_WAIT_DRAIN = 2'd1,
    UC_INFLIGHT   = 2'd2
  } state_e;

  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [BE_W-1:0]   be_mem_q   [DEPTH];
  logic [DEPTH-1:0]  uc_mem_q;

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [TID_W-1:0] tid_q, tid_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             err_q, err_d;
  state_e           state_q, state_d;

  logic q_full, q_empty, push, pop, head_uc, uc_inflight, issue_ok, st_uc;
  logic [CMP_W-1:0] addr_ext, base_ext, len_ext, addr_off;
  logic unused_rsp_tid;

  assign unused_rsp_tid = ^rsp_tid_i;

  // Region check widened by one bit so the subtraction can never wrap.
  assign addr_ext = CMP_W'(st_addr_i);
  assign base_ext = CMP_W'(CACHED_BASE);
  assign len_ext  = CMP_W'(CACHED_LEN);
  assign addr_off = addr_ext - base_ext;
  assign st_uc    = !((addr_ext >= base_ext) && (addr_off < len_ext));

  assign q_full      = (count_q == CNT_W'(DEPTH));
  assign q_empty     = (count_q == '0);
  assign head_uc     = uc_mem_q[head_q];
  assign uc_inflight = (state_q == UC_INFLIGHT);
  assign issue_ok    = head_uc ? (out_q == '0)
                               : ((out_q < OUT_W'(MAX_OUTSTANDING)) && !uc_inflight);

  assign st_ready_o    = !q_full && !flush_i && !rst_i;
  assign push          = st_valid_i && st_ready_o;
  assign req_valid_o   = !q_empty && issue_ok;
  assign pop           = req_valid_o && req_ready_i;
  assign req_addr_o    = addr_mem_q[head_q];
  assign req_data_o    = data_mem_q[head_q];
  assign req_be_o      = be_mem_q[head_q];
  assign req_uc_o      = !q_empty && head_uc;
  assign req_tid_o     = tid_q;
  assign empty_o       = q_empty && (out_q == '0);
  assign outstanding_o = out_q;
  assign rsp_err_o     = err_q;

  // Pointer, occupancy, TID and outstanding bookkeeping.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    tid_d   = tid_q;
    out_d   = out_q;
    err_d   = err_q;
    if (push) tail_d = tail_q + PTR_W'(1);
    if (pop) begin
      head_d = head_q + PTR_W'(1);
      tid_d  = tid_q + TID_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (pop && !rsp_valid_i) begin
      out_d = out_q + OUT_W'(1);
    end else if (!pop && rsp_valid_i) begin
      if (out_q == '0) err_d = 1'b1;
      else             out_d = out_q - OUT_W'(1);
    end
  end

  // Uncacheable serialisation FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pop && head_uc)                             state_d = UC_INFLIGHT;
        else if (!q_empty && head_uc && (out_q != '0))  state_d = UC_WAIT_DRAIN;
      end
      UC_WAIT_DRAIN: if (pop)                           state_d = UC_INFLIGHT;
      UC_INFLIGHT:   if (!pop && (out_d == '0))         state_d = IDLE;
      default:                                          state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      tid_q    <= '0;
      out_q    <= '0;
      err_q    <= 1'b0;
      uc_mem_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      tid_q   <= tid_d;
      out_q   <= out_d;
      err_q   <= err_d;
      if (push) uc_mem_q[tail_q] <= st_uc;
    end
  end

  // Payload storage needs no reset; it is only read when the entry is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_mem_q[tail_q] <= st_addr_i;
      data_mem_q[tail_q] <= st_data_i;
      be_mem_q[tail_q]   <= st_be_i;
    end
  end

endmodule

// File: tb/tb_dcache_store_queue.sv
// Bench for dcache_store_queue: a cycle model plus scoreboard predicts every request
// and handshake output; directed phases cover throttling, full queue, uc serialisation, flush and reset.
module tb_dcache_store_queue;

  localparam int DEPTH = 8;
  localparam int MAXO  = 7;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
    logic        uc;
  } exp_t;

  logic        clk;
  logic        rst_i, flush_i, st_valid_i, st_ready_o;
  logic [63:0] st_addr_i, st_data_i;
  logic [7:0]  st_be_i;
  logic        req_valid_o, req_ready_i, req_uc_o;
  logic [63:0] req_addr_o, req_data_o;
  logic [7:0]  req_be_o;
  logic [2:0]  req_tid_o, rsp_tid_i;
  logic        rsp_valid_i, empty_o, rsp_err_o;
  logic [3:0]  outstanding_o;

  dcache_store_queue dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .st_valid_i(st_valid_i), .st_ready_o(st_ready_o), .st_addr_i(st_addr_i),
    .st_data_i(st_data_i), .st_be_i(st_be_i),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_addr_o(req_addr_o),
    .req_data_o(req_data_o), .req_be_o(req_be_o), .req_uc_o(req_uc_o), .req_tid_o(req_tid_o),
    .rsp_valid_i(rsp_valid_i), .rsp_tid_i(rsp_tid_i),
    .empty_o(empty_o), .outstanding_o(outstanding_o), .rsp_err_o(rsp_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks, n_errors, cyc, m_out, n_issued, n_acked, rsp_dly, n_uc_iss, uc_base;
  int   iss_cyc [1024];
  exp_t sb [$];
  logic m_err, m_ucinf, last_acc;
  logic [2:0] m_tid;
  bit   mon_on, auto_rsp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic model_uc(input logic [63:0] a);
    return !((a >= 64'h8000_0000) && (a <= 64'hBFFF_FFFF));
  endfunction

  // Compare DUT outputs against the model just before the edge, then advance the model.
  task automatic monitor();
    exp_t h, e;
    logic hok, iss, acc;
    if (!mon_on) return;
    check("st_ready", 64'(st_ready_o), 64'((sb.size() < DEPTH) && !flush_i && !rst_i));
    hok = 1'b0;
    if (sb.size() != 0) begin
      h   = sb[0];
      hok = h.uc ? (m_out == 0) : ((m_out < MAXO) && !m_ucinf);
    end
    check("req_valid", 64'(req_valid_o), 64'(hok));
    if (req_valid_o && hok) begin
      check("req_addr", req_addr_o, h.addr);
      check("req_data", req_data_o, h.data);
      check("req_be", 64'(req_be_o), 64'(h.be));
      check("req_uc", 64'(req_uc_o), 64'(h.uc));
      check("req_tid", 64'(req_tid_o), 64'(m_tid));
    end
    check("outstanding", 64'(outstanding_o), 64'(m_out));
    check("empty", 64'(empty_o), 64'((sb.size() == 0) && (m_out == 0)));
    check("rsp_err", 64'(rsp_err_o), 64'(m_err));
    acc = st_valid_i && st_ready_o;
    last_acc = acc;
    if (rst_i) begin
      sb.delete();
      m_out = 0; m_err = 1'b0; m_ucinf = 1'b0; m_tid = 3'd0;
      n_acked = n_issued;
    end else begin
      iss = req_valid_o && req_ready_i;
      if (iss) begin
        if (req_uc_o) begin
          check("uc_issue_idle", 64'(outstanding_o), 64'd0);
          n_uc_iss++;
        end
        if (sb.size() != 0) begin
          h = sb.pop_front();
          if (h.uc) m_ucinf = 1'b1;
        end
        m_tid++;
        iss_cyc[n_issued % 1024] = cyc;
        n_issued++;
      end
      if (acc) begin
        e.addr = st_addr_i; e.data = st_data_i; e.be = st_be_i; e.uc = model_uc(st_addr_i);
        sb.push_back(e);
      end
      if (iss && !rsp_valid_i) m_out++;
      else if (!iss && rsp_valid_i) begin
        if (m_out == 0) m_err = 1'b1;
        else            m_out--;
      end
      if (m_out == 0) m_ucinf = 1'b0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
    rsp_valid_i = 1'b0;
    if (auto_rsp && (n_acked < n_issued) && (cyc >= iss_cyc[n_acked % 1024] + rsp_dly)) begin
      rsp_valid_i = 1'b1;
      rsp_tid_i   = 3'(n_acked);
      n_acked++;
    end
  endtask

  task automatic enq(input logic [63:0] a);
    st_valid_i = 1'b1;
    st_addr_i  = a;
    st_data_i  = {$urandom, $urandom};
    st_be_i    = 8'($urandom);
    last_acc   = 1'b0;
    for (int k = 0; k < 300; k++) begin
      step();
      if (last_acc) break;
    end
    st_valid_i = 1'b0;
    check("enq_accept", 64'(last_acc), 64'd1);
  endtask

  task automatic rsp_pulse();
    rsp_valid_i = 1'b1;
    rsp_tid_i   = 3'(n_acked);
    if (n_acked < n_issued) n_acked++;
    step();
  endtask

  task automatic wait_empty(input string tag);
    for (int k = 0; k < 500; k++) begin
      if (empty_o && (sb.size() == 0)) break;
      step();
    end
    check(tag, 64'(empty_o), 64'd1);
  endtask

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0; m_out = 0; n_issued = 0; n_acked = 0;
    rsp_dly = 0; n_uc_iss = 0; m_err = 1'b0; m_ucinf = 1'b0; m_tid = 3'd0;
    mon_on = 1'b0; auto_rsp = 1'b0; last_acc = 1'b0;
    rst_i = 1'b1; flush_i = 1'b0; st_valid_i = 1'b0; st_addr_i = '0; st_data_i = '0;
    st_be_i = '0; req_ready_i = 1'b0; rsp_valid_i = 1'b0; rsp_tid_i = '0;

    step(); step();
    check("rst_st_ready", 64'(st_ready_o), 64'd0);
    check("rst_req_valid", 64'(req_valid_o), 64'd0);
    check("rst_req_uc", 64'(req_uc_o), 64'd0);
    check("rst_req_tid", 64'(req_tid_o), 64'd0);
    check("rst_empty", 64'(empty_o), 64'd1);
    check("rst_outstanding", 64'(outstanding_o), 64'd0);
    check("rst_rsp_err", 64'(rsp_err_o), 64'd0);
    mon_on = 1'b1;
    rst_i  = 1'b0;
    step();

    // Throttle at MAX_OUTSTANDING; one ack releases the 8th store with TID 7.
    req_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) enq(64'h8000_0000 + 64'(8 * i));
    step(); step(); step();
    check("t1_out_max", 64'(outstanding_o), 64'd7);
    check("t1_8th_held", 64'(req_valid_o), 64'd0);
    check("t1_st_ready", 64'(st_ready_o), 64'd1);
    check("t1_8th_tid", 64'(req_tid_o), 64'd7);
    rsp_pulse();
    step();
    check("t1_out_after", 64'(outstanding_o), 64'd7);
    auto_rsp = 1'b1; rsp_dly = 0;
    wait_empty("t1_drain");
    auto_rsp = 1'b0;

    // Full queue with the cache stalled; no room until a pop has happened.
    req_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) enq(64'h8000_1000 + 64'(8 * i));
    #1;
    check("t2_full_ready", 64'(st_ready_o), 64'd0);
    st_valid_i = 1'b1;
    st_addr_i  = 64'h8000_1040;
    repeat (3) step();
    check("t2_9th_blocked", 64'(last_acc), 64'd0);
    req_ready_i = 1'b1;
    enq(64'h8000_1040);
    auto_rsp = 1'b1; rsp_dly = 2;
    wait_empty("t2_drain");

    // Uncacheable store serialised between two cacheable stores.
    rsp_dly  = 5;
    uc_base  = n_uc_iss;
    enq(64'h8000_0000);
    enq(64'h1000_0000);
    enq(64'h8000_0040);
    wait_empty("t3_drain");
    check("t3_uc_count", 64'(n_uc_iss - uc_base), 64'd1);

    // Region boundaries.
    rsp_dly = 1;
    uc_base = n_uc_iss;
    enq(64'h7FFF_FFFF);
    enq(64'h8000_0000);
    enq(64'hBFFF_FFFF);
    enq(64'hC000_0000);
    enq(64'hFFFF_FFFF_FFFF_FFF8);
    wait_empty("t4_drain");
    check("t4_uc_count", 64'(n_uc_iss - uc_base), 64'd3);
    auto_rsp = 1'b0;

    // Simultaneous issue and ack, then an ack with nothing outstanding.
    for (int i = 0; i < 4; i++) enq(64'h8000_2000 + 64'(8 * i));
    rsp_valid_i = 1'b1;
    rsp_tid_i   = 3'(n_acked);
    n_acked++;
    step();
    check("t5_same_cycle", 64'(outstanding_o), 64'd3);
    repeat (3) rsp_pulse();
    check("t5_out_zero", 64'(outstanding_o), 64'd0);
    rsp_pulse();
    check("t5_rsp_err", 64'(rsp_err_o), 64'd1);
    check("t5_out_stays0", 64'(outstanding_o), 64'd0);

    // Flush drains queued entries.
    req_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) enq(64'h8000_3000 + 64'(8 * i));
    flush_i = 1'b1;
    #1;
    check("t6_flush_ready", 64'(st_ready_o), 64'd0);
    req_ready_i = 1'b1;
    auto_rsp = 1'b1; rsp_dly = 2;
    wait_empty("t6_flush_drain");
    flush_i = 1'b0;

    // Reset in the middle of a flush drain; a late ack then counts as an error.
    auto_rsp = 1'b0;
    req_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) enq(64'h8000_4000 + 64'(8 * i));
    flush_i = 1'b1;
    req_ready_i = 1'b1;
    auto_rsp = 1'b1; rsp_dly = 4;
    repeat (3) step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    auto_rsp = 1'b0;
    #1;
    check("t7_empty", 64'(empty_o), 64'd1);
    check("t7_req_valid", 64'(req_valid_o), 64'd0);
    check("t7_outstanding", 64'(outstanding_o), 64'd0);
    check("t7_err_cleared", 64'(rsp_err_o), 64'd0);
    rsp_pulse();
    check("t7_late_ack_err", 64'(rsp_err_o), 64'd1);
    flush_i = 1'b0;
    step(); step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dcache_store_queue.md
# dcache_store_queue

In-order store request queue between the store unit and the HPDcache request port of the CVA6 64-bit core. It buffers committed stores and classifies each one as cacheable or uncacheable against the cached region (DRAM window 0x8000_0000 + 0x4000_0000). It tags each issued request with a transaction ID and throttles issue to the configured maximum number of outstanding stores. It also serialises uncacheable stores so that no other store is in flight alongside one.

## Interface
Parameters:
- DEPTH, 8: queue entries (power of two, ≥2)
- ADDR_W, 64: address width
- DATA_W, 64: store data width; byte-enable width is DATA_W/8
- TID_W, 3: transaction ID width
- MAX_OUTSTANDING, 7: maximum issued-but-unacknowledged stores (1..2^TID_W−1)
- CACHED_BASE, 64'h8000_0000: cached region base
- CACHED_LEN, 64'h4000_0000: cached region length

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset; synchronous, active-high
- flush_i  in  1  stop accepting new stores and drain
- st_valid_i  in  1  store request valid
- st_ready_o  out  1  queue can accept
- st_addr_i  in  ADDR_W  store byte address
- st_data_i  in  DATA_W  store data
- st_be_i  in  DATA_W/8  byte enables
- req_valid_o  out  1  request to cache valid
- req_ready_i  in  1  cache accepts request
- req_addr_o  out  ADDR_W  head address
- req_data_o  out  DATA_W  head data
- req_be_o  out  DATA_W/8  head byte enables
- req_uc_o  out  1  head is uncacheable
- req_tid_o  out  TID_W  transaction ID of the head
- rsp_valid_i  in  1  write acknowledge
- rsp_tid_i  in  TID_W  ID of the acknowledged store (informational; not checked for order)
- empty_o  out  1  queue empty and zero outstanding
- outstanding_o  out  TID_W+1  current outstanding count
- rsp_err_o  out  1  sticky: acknowledge received while outstanding was 0

## Operation
- Enqueue on st_valid_i && st_ready_o. Enqueue writes the entry at the tail pointer and increments the tail mod DEPTH.
- st_ready_o = !full && !flush_i && !rst_i. A pop in the same cycle does not make room (no look-ahead).
- Classification is done at enqueue and stored with the entry. uc = !(addr ≥ CACHED_BASE && addr − CACHED_BASE < CACHED_LEN). The comparison is unsigned at ADDR_W+1 bits so no wrap occurs.
- Occupancy counter range is 0..DEPTH. full = (count == DEPTH); empty = (count == 0).
- req_valid_o = !empty && issue_ok. Head fields are driven directly from the entry at the head pointer.
- issue_ok depends on the head entry:
  - Cacheable head: issue_ok = (outstanding < MAX_OUTSTANDING) && !uc_inflight.
  - Uncacheable head: issue_ok = (outstanding == 0).
- Issue occurs on req_valid_o && req_ready_i. On issue:
  - the head pointer increments;
  - tid_cnt increments mod 2^TID_W;
  - the outstanding count increments;
  - uc_inflight is set if the entry was uncacheable.
- req_tid_o = tid_cnt.
- rsp_valid_i decrements the outstanding count.
  - Issue and response in the same cycle leave the count unchanged.
  - A response while the count is 0 leaves the count at 0 and sets rsp_err_o.
- uc_inflight clears when the outstanding count becomes 0.
- Flush: while flush_i is high, no enqueue. Queued entries keep issuing normally. empty_o signals drain completion.
- FSM (for the uncacheable path): IDLE, UC_WAIT_DRAIN, UC_INFLIGHT.
  - IDLE → UC_WAIT_DRAIN when the head is uc and outstanding > 0.
  - UC_WAIT_DRAIN → UC_INFLIGHT on issue of the uc head.
  - IDLE → UC_INFLIGHT on direct issue of a uc head when outstanding == 0.
  - UC_INFLIGHT → IDLE when the outstanding count reaches 0.
  - uc_inflight = (state == UC_INFLIGHT).

## Timing
- Reset values: all pointers, counters and tid_cnt are 0; state is IDLE.
  - Outputs: st_ready_o=0 while rst_i is high; req_valid_o=0; req_uc_o=0; req_tid_o=0; empty_o=1; outstanding_o=0; rsp_err_o=0.
  - Data/addr/be outputs: don't care while req_valid_o=0.
- Reset asserted mid-operation discards all queued entries and outstanding state on the next edge. Late acknowledges after reset are counted as errors.
- Latency: a store enqueued in cycle N can appear on req_valid_o in cycle N+1 at the earliest. There is no combinational path from st_* to req_*.
- req_valid_o, once high, stays high with stable fields until req_ready_i. The only exception is reset.
- Response-to-issue: a count decrement in cycle N enables issue in cycle N+1.
- Sustained throughput is one store per cycle while cacheable and below MAX_OUTSTANDING.

## Test plan
- Reset, then enqueue 8 cacheable stores (addr 0x8000_0000 + 8·i) with req_ready_i=1 and no responses:
  - 7 issue, with TIDs 0..6;
  - the 8th waits, st_ready_o stays 1, outstanding_o=7;
  - one response releases the 8th, with TID 7.
- Hold req_ready_i=0 and enqueue 8 stores: st_ready_o drops after the 8th; a 9th valid store is not accepted until a pop.
- Sequence cacheable 0x8000_0000, uncacheable 0x1000_0000, cacheable 0x8000_0040, with responses delayed 5 cycles:
  - the uc store issues only when outstanding_o=0 with req_uc_o=1;
  - the following cacheable store issues only after the uc acknowledge.
- Boundary addresses: 0x7FFF_FFFF → uc=1; 0x8000_0000 → uc=0; 0xBFFF_FFFF → uc=0; 0xC000_0000 → uc=1; 0xFFFF_FFFF_FFFF_FFF8 → uc=1.
- Issue and response in the same cycle at outstanding_o=3 → stays 3. A response at outstanding_o=0 → rsp_err_o=1 and the count stays 0.
- Flush with 4 queued entries: st_ready_o=0 immediately; all 4 issue; empty_o=1 after the last acknowledge. Asserting rst_i mid-drain → empty_o=1 and req_valid_o=0 on the next cycle.
